// File: rtl/dsp_pkg.sv
// Shared constants and helpers for the DSP result collector and its FIFO.
package dsp_pkg;

    localparam int P_WIDTH     = 48;
    localparam int DSP_LATENCY = 4;
    localparam int FIFO_DEPTH  = 8;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding captured DSP results; extra pointer MSB distinguishes full from empty.
module result_fifo
    import dsp_pkg::*;
#(
    parameter int WIDTH = P_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [clog2(DEPTH):0]  o_count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr                <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + (AW+1)'(1);
            end
        end
    end

    assign o_data  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/dsp_result_collector.sv
// Issues ops into a fixed-latency DSP slice, tracks them with tokens and buffers results under credits.
module dsp_result_collector
    import dsp_pkg::*;
#(
    parameter int WIDTH   = P_WIDTH,
    parameter int LATENCY = DSP_LATENCY,
    parameter int DEPTH   = FIFO_DEPTH
) (
    input  logic                   CLK,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    output logic                   dsp_ce,
    input  logic [WIDTH-1:0]       p_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [clog2(DEPTH):0]  level,
    output logic                   overflow
);

    // Handshakes: a transfer happens in any cycle where valid && ready; ready never waits on valid.

    localparam int              LW      = clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   L_DEPTH = LW'(DEPTH);

    logic [LATENCY-1:0] r_tok;
    logic [LW-1:0]      r_level;
    logic               r_overflow;
    logic               w_fire;
    logic               w_pop;
    logic               w_push;
    logic               w_ce;
    logic               w_issue_ready;
    logic               w_full;
    logic               w_empty;
    logic [LW-1:0]      w_fifo_count;

    assign w_pop         = !w_empty && m_ready;
    assign w_issue_ready = !flush && ((r_level < L_DEPTH) || ((r_level == L_DEPTH) && w_pop));
    assign w_fire        = issue_valid && w_issue_ready;
    // Pending tokens keep the slice clocked, so a fired op can never stall mid-pipe.
    assign w_ce          = w_fire || (|r_tok);
    assign w_push        = w_ce && r_tok[LATENCY-1] && !flush;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_tok <= '0;
        end else if (flush) begin
            r_tok <= '0;
        end else if (w_ce) begin
            r_tok[0] <= w_fire;
            for (int i = 1; i < LATENCY; i++) begin
                r_tok[i] <= r_tok[i-1];
            end
        end
    end

    // Level counts credits: in-flight tokens plus FIFO entries; a push only moves a credit.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (flush) begin
            r_level <= '0;
        end else if (w_fire && !w_pop) begin
            r_level <= r_level + LW'(1);
        end else if (!w_fire && w_pop) begin
            r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (rst_n),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (p_in),
        .o_data  (m_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    a_no_drop: assert property (@(posedge CLK) disable iff (!rst_n) !(w_push && w_full && !w_pop));
    a_credits: assert property (@(posedge CLK) disable iff (!rst_n) (r_level >= w_fifo_count));

    assign issue_ready = w_issue_ready;
    assign dsp_ce      = w_ce;
    assign m_valid     = !w_empty;
    assign level       = r_level;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Directed bench for dsp_result_collector with a behavioural CE-gated DSP pipe and result scoreboard.
module tb_dsp_result_collector;

    localparam int W = 48;
    localparam int L = 4;
    localparam int D = 8;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          issue_valid;
    logic          issue_ready;
    logic          dsp_ce;
    logic [W-1:0]  p_in;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [3:0]    level;
    logic          overflow;
    logic [W-1:0]  op_data;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_q[$];
    int            lvl_model = 0;
    logic [W-1:0]  dsp_st [L];

    always #5 CLK = ~CLK;

    dsp_result_collector #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .dsp_ce      (dsp_ce),
        .p_in        (p_in),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .level       (level),
        .overflow    (overflow)
    );

    // DSP slice model: every stage advances on dsp_ce only, reset by the same rst_n.
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) dsp_st[i] <= '0;
        end else if (dsp_ce) begin
            dsp_st[0] <= op_data;
            for (int i = 1; i < L; i++) dsp_st[i] <= dsp_st[i-1];
        end
    end
    assign p_in = dsp_st[L-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and credit model, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!rst_n) begin
            exp_q.delete();
            lvl_model = 0;
        end else begin
            check("level", 64'(level), 64'(lvl_model));
            check("overflow", 64'(overflow), 64'd0);
            if (flush) begin
                exp_q.delete();
                lvl_model = 0;
            end else begin
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
                    else check("m_data", 64'(m_data), 64'(exp_q.pop_front()));
                    lvl_model--;
                end
                if (issue_valid && issue_ready) begin
                    exp_q.push_back(op_data);
                    lvl_model++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Fire one op (must be accepted immediately) and measure cycles until m_valid.
    task automatic single_op(input string tag, input logic [W-1:0] val);
        int lat;
        m_ready     = 1'b1;
        issue_valid = 1'b1;
        op_data     = val;
        tick();
        issue_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_data"}, 64'(m_data), 64'(val));
        tick();
        check({tag, "_drained"}, 64'(m_valid), 64'd0);
    endtask

    initial begin
        int fires;
        int guard;
        logic [15:0] ce_seen;
        logic [15:0] ce_exp;

        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; op_data = '0; m_ready = 1'b0;
        tick(); tick();
        check("rst_level", 64'(level), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_dsp_ce", 64'(dsp_ce), 64'd0);
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Reset mid-stream with three tokens in flight.
        issue_valid = 1'b1;
        op_data = 48'hA1; tick();
        op_data = 48'hA2; tick();
        op_data = 48'hA3; tick();
        issue_valid = 1'b0;
        #1;
        check("t1_level_pre", 64'(level), 64'd3);
        check("t1_ce_pre", 64'(dsp_ce), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t1_level", 64'(level), 64'd0);
        check("t1_m_valid", 64'(m_valid), 64'd0);
        check("t1_m_data", 64'(m_data), 64'd0);
        check("t1_dsp_ce", 64'(dsp_ce), 64'd0);
        check("t1_issue_ready", 64'(issue_ready), 64'd1);
        check("t1_overflow", 64'(overflow), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        single_op("t2", 48'h1234);

        // Back-pressure: credits stop issue at eight.
        m_ready = 1'b0;
        issue_valid = 1'b1;
        fires = 0;
        for (int c = 0; c < 20; c++) begin
            op_data = 48'h300 + 48'(c);
            @(negedge CLK);
            if (issue_valid && issue_ready) fires++;
            tick();
        end
        check("t3_fires", 64'(fires), 64'd8);
        check("t3_issue_ready", 64'(issue_ready), 64'd0);
        check("t3_level", 64'(level), 64'd8);
        check("t3_m_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            op_data = 48'h400 + 48'(c);
            @(negedge CLK);
            if (c == 0) check("t4_ready_on_pop_at_full", 64'(issue_ready), 64'd1);
            if (issue_valid && issue_ready) fires++;
            tick();
        end
        check("t4_fires", 64'(fires), 64'd6);
        check("t4_level", 64'(level), 64'd8);
        issue_valid = 1'b0;
        guard = 0;
        while (level != 0 && guard < 40) begin
            tick();
            guard++;
        end
        check("t3_drain_level", 64'(level), 64'd0);
        check("t3_drain_queue", 64'(exp_q.size()), 64'd0);

        // Gapped issue at cycles 0, 2 and 9.
        m_ready = 1'b1;
        ce_seen = '0;
        ce_exp  = 16'b0011_1110_0111_1111;
        for (int c = 0; c < 16; c++) begin
            issue_valid = (c == 0) || (c == 2) || (c == 9);
            op_data     = (c == 0) ? 48'd1 : ((c == 2) ? 48'd2 : 48'd3);
            @(negedge CLK);
            ce_seen[c] = dsp_ce;
            tick();
        end
        issue_valid = 1'b0;
        check("t5_ce_pattern", 64'(ce_seen), 64'(ce_exp));
        check("t5_queue", 64'(exp_q.size()), 64'd0);

        // Flush with three buffered and two in flight.
        m_ready = 1'b0;
        issue_valid = 1'b1;
        op_data = 48'h61; tick();
        op_data = 48'h62; tick();
        op_data = 48'h63; tick();
        issue_valid = 1'b0;
        repeat (6) tick();
        check("t6_buffered_valid", 64'(m_valid), 64'd1);
        check("t6_buffered_level", 64'(level), 64'd3);
        issue_valid = 1'b1;
        op_data = 48'h64; tick();
        op_data = 48'h65; tick();
        check("t6_level_pre", 64'(level), 64'd5);
        flush = 1'b1;
        op_data = 48'h66;
        #1;
        check("t6_ready_in_flush", 64'(issue_ready), 64'd0);
        check("t6_ce_in_flush", 64'(dsp_ce), 64'd1);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        check("t6_m_valid", 64'(m_valid), 64'd0);
        check("t6_level", 64'(level), 64'd0);
        repeat (6) tick();
        check("t6_no_ghost", 64'(m_valid), 64'd0);
        single_op("t6_after", 48'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
